// File: rtl/cskipa_pipe.sv
// cskipa_pipe: pipelined carry-skip adder with a valid/ready handshake.
// Operands are cut into BLOCK-bit ripple groups with a skip mux per group.
// The groups are spread evenly over STAGES register stages. Each stage passes
// its carry, the sum bits finished so far and the operand bits still to be
// added down the pipe.
// Optional feature macro: CSKIPA_PIPE_SUB_EN adds the i_sub port. With
// i_sub=1 the block computes A + ~B + 1, and i_cin is ignored.

module cskipa_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
`ifdef CSKIPA_PIPE_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int BPS  = NBLK / STAGES;
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH % BLOCK != 0) begin : g_err_width
        $error("cskipa_pipe: WIDTH must be a multiple of BLOCK");
    end
    if (STAGES < 1 || (NBLK % STAGES) != 0) begin : g_err_stages
        $error("cskipa_pipe: WIDTH/BLOCK must be a multiple of STAGES");
    end

    // Operand conditioning at the pipe entry: subtraction is add of ~B with carry 1
    logic [WIDTH-1:0] in_b;
    logic             in_c;
`ifdef CSKIPA_PIPE_SUB_EN
    assign in_b = i_sub ? ~i_add_term2 : i_add_term2;
    assign in_c = i_sub ? 1'b1 : i_cin;
`else
    assign in_b = i_add_term2;
    assign in_c = i_cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned BASE = k * BPS * BLOCK;

        logic             st_v;
        logic             st_c;
        logic [WIDTH-1:0] st_a;
        logic [WIDTH-1:0] st_b;
        logic [WIDTH-1:0] st_s;
        logic [WIDTH-1:0] nx_s;
        logic             nx_c;
        logic             nx_m;
        logic             v_q;
        logic             c_q;
        logic             m_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             ld;

        if (k == 0) begin : g_head
            assign st_v = i_valid;
            assign st_c = in_c;
            assign st_a = i_add_term1;
            assign st_b = in_b;
            assign st_s = '0;
        end else begin : g_body
            assign st_v = g_stg[k-1].v_q;
            assign st_c = g_stg[k-1].c_q;
            assign st_a = g_stg[k-1].a_q;
            assign st_b = g_stg[k-1].b_q;
            assign st_s = g_stg[k-1].s_q;
        end

        // A stage loads when it is empty or when its content moves on this cycle
        if (k == STAGES - 1) begin : g_tail
            logic unused_ab;
            assign ld        = !v_q || i_ready;
            assign unused_ab = ^{a_q, b_q};
        end else begin : g_mid
            logic unused_m;
            assign ld       = !v_q || g_stg[k+1].ld;
            assign unused_m = m_q;
        end

        // Ripple each group of this stage, then skip its carry when all bits propagate
        always_comb begin : p_add
            logic             c;
            logic             cg;
            logic             p;
            logic             rc;
            logic             x;
            int unsigned      bit_i;
            logic [IW-1:0]    ix;
            nx_s = st_s;
            nx_m = 1'b0;
            c    = st_c;
            for (int unsigned g = 0; g < BPS; g++) begin
                cg = c;
                p  = 1'b1;
                rc = c;
                for (int unsigned j = 0; j < BLOCK; j++) begin
                    bit_i = BASE + g * BLOCK + j;
                    ix    = IW'(bit_i);
                    if (bit_i == WIDTH - 1) begin
                        nx_m = rc;
                    end
                    x        = st_a[ix] ^ st_b[ix];
                    nx_s[ix] = x ^ rc;
                    p        = p & x;
                    rc       = (st_a[ix] & st_b[ix]) | (rc & x);
                end
                c = p ? cg : rc;
            end
            nx_c = c;
        end

        // Stage register: holds while the stage is full and its successor is blocked
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                m_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else if (ld) begin
                v_q <= st_v;
                c_q <= nx_c;
                m_q <= nx_m;
                a_q <= st_a;
                b_q <= st_b;
                s_q <= nx_s;
            end
        end
    end

    assign o_ready = g_stg[0].ld;
    assign o_valid = g_stg[STAGES-1].v_q;
    assign o_sum   = g_stg[STAGES-1].s_q;
    assign o_cout  = g_stg[STAGES-1].c_q;
    assign o_ovf   = g_stg[STAGES-1].m_q ^ g_stg[STAGES-1].c_q;

endmodule

// File: tb/tb_cskipa_pipe.sv
// Scoreboard bench for cskipa_pipe: the driver pushes the arithmetic result
// expected for each accepted operand set. A separate monitor pops and compares
// on every output transfer.

module tb_cskipa_pipe;

    localparam int W  = 32;
    localparam int BL = 4;
    localparam int ST = 2;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_add_term1;
    logic [W-1:0] i_add_term2;
    logic         i_cin;
`ifdef CSKIPA_PIPE_SUB_EN
    logic         i_sub;
`endif
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_ovf;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   rdy_mode = 1;

    cskipa_pipe #(.WIDTH(W), .BLOCK(BL), .STAGES(ST)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (i_add_term1),
        .i_add_term2 (i_add_term2),
        .i_cin       (i_cin),
`ifdef CSKIPA_PIPE_SUB_EN
        .i_sub       (i_sub),
`endif
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
        .o_ovf       (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Downstream readiness: 0 = stall, 1 = always ready, 2 = random
    initial i_ready = 1'b1;
    always begin
        @(negedge i_clk);
        if (rdy_mode == 2) i_ready = 1'($urandom_range(0, 1));
        else               i_ready = (rdy_mode == 1);
    end

    // Reference: plain integer arithmetic and sign rules
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        exp_t       e;
        logic [W:0] full;
        if (sb) begin
            e.s = a - b;
            e.c = (a >= b);
            e.v = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            e.s  = full[W-1:0];
            e.c  = full[W];
            e.v  = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb);
        int   n   = 0;
        logic acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge i_clk);
            i_valid     = 1'b1;
            i_add_term1 = a;
            i_add_term2 = b;
            i_cin       = ci;
`ifdef CSKIPA_PIPE_SUB_EN
            i_sub       = sb;
`endif
            #1 acc = o_ready;
            @(posedge i_clk);
            n++;
        end
        if (acc) q.push_back(model(a, b, ci, sb));
        else begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept t=%0t", $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_valid     = 1'b0;
            i_add_term1 = W'({$urandom(), $urandom()});
            i_add_term2 = W'({$urandom(), $urandom()});
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when o_valid && i_ready
    always begin
        exp_t e;
        @(negedge i_clk);
        #2;
        if (!i_rst && o_valid && i_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=%h required=none t=%0t", o_sum, $time);
            end else begin
                e = q.pop_front();
                chk("result", {o_sum, o_cout, o_ovf}, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb;
        exp_t         e1;

        i_rst = 1'b0; i_valid = 1'b0; i_cin = 1'b0;
        i_add_term1 = '0; i_add_term2 = '0;
`ifdef CSKIPA_PIPE_SUB_EN
        i_sub = 1'b0;
`endif
        #2 i_rst = 1'b1;
        #1;
        chk("rst_valid", (W+2)'(o_valid), '0);
        chk("rst_data", {o_sum, o_cout, o_ovf}, '0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1 chk("rst_ready", (W+2)'(o_ready), (W+2)'(1));

        // Full skip chain across every stage, plus latency
        rdy_mode = 1;
        send('1, '0, 1'b1, 1'b0);
        for (int i = 1; i <= ST; i++) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            #1 chk("latency", (W+2)'(o_valid), (W+2)'(i == ST));
        end
        drain();

        // Signed overflow, then back-to-back wrap
        send({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0);
        send({1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b0);
        idle(1);
        drain();

        // Backpressure: two accepted, third stalls, output held stable
        rdy_mode = 0;
        e1 = model(W'(32'h1234_5678), W'(32'h0FED_CBA9), 1'b1, 1'b0);
        send(W'(32'h1234_5678), W'(32'h0FED_CBA9), 1'b1, 1'b0);
        send(W'(32'hFFFF_0000), W'(32'h0001_FFFF), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_valid     = 1'b1;
            i_add_term1 = W'(32'hAAAA_AAAA);
            i_add_term2 = W'(32'h5555_5555);
            i_cin       = 1'b1;
            #1;
            chk("bp_ready_low", (W+2)'(o_ready), '0);
            chk("bp_valid", (W+2)'(o_valid), (W+2)'(1));
            chk("bp_hold", {o_sum, o_cout, o_ovf}, e1);
        end
        rdy_mode = 1;
        send(W'(32'hAAAA_AAAA), W'(32'h5555_5555), 1'b1, 1'b0);
        idle(1);
        drain();

        // Random streaming with random gaps and backpressure
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            a  = W'({$urandom(), $urandom()});
            b  = ($urandom_range(0, 7) == 0) ? ~a : W'({$urandom(), $urandom()});
            ci = 1'($urandom_range(0, 1));
`ifdef CSKIPA_PIPE_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            send(a, b, ci, sb);
        end
        idle(1);
        rdy_mode = 1;
        drain();

        // Reset with results in flight: nothing stale may appear afterwards
        send(W'(32'h0000_0011), W'(32'h0000_0022), 1'b0, 1'b0);
        send(W'(32'h0000_0033), W'(32'h0000_0044), 1'b1, 1'b0);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", (W+2)'(o_valid), '0);
        chk("mid_rst_sum", (W+2)'(o_sum), '0);
        q.delete();
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rst   = 1'b0;
        #1 chk("post_rst_ready", (W+2)'(o_ready), (W+2)'(1));
        idle(10);

`ifdef CSKIPA_PIPE_SUB_EN
        send(W'(5), W'(7), 1'b0, 1'b1);
        send(W'(7), W'(5), 1'b0, 1'b1);
        send('1, '0, 1'b1, 1'b0);
        idle(1);
        drain();
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
